// File: rtl/scrambler_pkg.sv
// Shared types and defaults for the keystream XOR stage that sits behind
// the 34-bit primary LFSR.
package scrambler_pkg;

    localparam int DATA_WIDTH_DEF = 18;
    localparam int POLY_WIDTH_DEF = 34;
    localparam int KS_LSB_DEF     = 16;
    localparam int FRAME_LEN_DEF  = 256;
    localparam int CNT_W          = $clog2(FRAME_LEN_DEF + 1);

    typedef enum logic [1:0] {
        SEED_WAIT = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    // Word counter sticks at its maximum rather than wrapping back into range.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/scrambler_xor_stage_fifo.sv
// Two-entry skid buffer carrying {sof, eof, data}. Pure storage: push/pop
// with occupancy flags; the read port always shows the oldest entry.
module scr_skid_fifo #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/scrambler_xor_stage.sv
// XORs accepted words with a slice of the LFSR state, advances the LFSR once
// per scrambled word, and tracks framing / seed health with sticky flags.
module scrambler_xor_stage
    import scrambler_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int POLY_WIDTH = POLY_WIDTH_DEF,
    parameter int KS_LSB     = KS_LSB_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bypass,
    input  logic                  err_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [POLY_WIDTH-1:0] ks_in,
    output logic                  lfsr_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  seed_err,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int                 FIFO_W  = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0]   LEN_MAX = CNT_W'(FRAME_LEN);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ks_nz;
    logic                    r_byp_q;
    logic                    r_frame_open;
    logic [CNT_W-1:0]        r_word_cnt;
    logic                    r_seed_err;
    logic                    r_frame_err;

    logic [DATA_WIDTH-1:0]   w_ks_slice;
    logic                    w_ks_zero;
    logic                    w_permit;
    logic                    w_accept;
    logic                    w_eff_byp;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_seed_fault;
    logic                    w_in_frame;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_len_hit;
    logic                    w_open_next;
    logic                    w_frame_viol;
    logic [FIFO_W-1:0]       w_pop_data;
    logic [1:0]              w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;

    assign w_ks_slice = ks_in[KS_LSB +: DATA_WIDTH];
    assign w_ks_zero  = (ks_in == '0);

    // Before a seed is present only bypassed traffic may enter.
    assign w_permit = (r_state == RUN) | ((r_state == SEED_WAIT) & bypass);
    assign in_ready = w_permit & ~w_full;
    assign w_accept = in_valid & in_ready;

    // The bypass choice is latched on sof; mid-frame changes are ignored.
    assign w_eff_byp   = (r_state != RUN) | (in_sof ? bypass : r_byp_q);
    assign lfsr_enable = w_accept & ~w_eff_byp;
    assign w_word      = in_data ^ (w_eff_byp ? '0 : w_ks_slice);

    // A locked (all-zero) LFSR is only harmful when words are being scrambled.
    assign w_seed_fault = (r_state == RUN) & w_ks_zero & (~r_byp_q | lfsr_enable);

    assign w_in_frame   = in_sof | r_frame_open;
    assign w_cnt_next   = in_sof ? CNT_W'(1) : cnt_inc_sat(r_word_cnt);
    assign w_len_hit    = w_in_frame & ~in_eof & (w_cnt_next == LEN_MAX);
    assign w_open_next  = w_in_frame & ~in_eof & ~w_len_hit;
    assign w_frame_viol = w_accept & ((in_sof & r_frame_open) |
                                      (~in_sof & ~r_frame_open) |
                                      w_len_hit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEED_WAIT: if (r_ks_nz)            w_state_nxt = RUN;
            RUN:       if (w_seed_fault)       w_state_nxt = FLUSH;
            FLUSH:     if (w_count == 2'd0)    w_state_nxt = SEED_WAIT;
            default:                           w_state_nxt = SEED_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SEED_WAIT;
            r_ks_nz      <= 1'b0;
            r_byp_q      <= 1'b0;
            r_frame_open <= 1'b0;
            r_word_cnt   <= '0;
            r_seed_err   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ks_nz <= ~w_ks_zero;
            if (w_accept) begin
                r_word_cnt   <= w_cnt_next;
                r_frame_open <= w_open_next;
                if (in_sof) begin
                    r_byp_q <= bypass;
                end
            end
            // A new error in the same cycle as err_clr takes priority.
            if (w_seed_fault) begin
                r_seed_err <= 1'b1;
            end else if (err_clr) begin
                r_seed_err <= 1'b0;
            end
            if (w_frame_viol) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign w_pop = out_valid & out_ready;

    scr_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data ({in_sof, in_eof, w_word}),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_sof   = w_pop_data[FIFO_W-1];
    assign out_eof   = w_pop_data[FIFO_W-2];
    assign out_data  = w_pop_data[DATA_WIDTH-1:0];
    assign seed_err  = r_seed_err;
    assign frame_err = r_frame_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_scrambler_xor_stage.sv
// Randomized bench for scrambler_xor_stage: a transaction-level model of the
// framing/keystream rules plus an LFSR driving ks_in.
module tb_scrambler_xor_stage;

    localparam int DW = 18;
    localparam int PW = 34;
    localparam int KL = 16;
    localparam int FL = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bypass = 1'b0;
    logic          err_clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_eof = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] ks_in;
    logic [PW-1:0] ks_fixed = '0;
    logic [PW-1:0] lfsr_q;
    logic [PW-1:0] lfsr_seed = '0;
    logic          use_lfsr = 1'b0;
    logic          lfsr_load = 1'b0;

    logic          in_ready;
    logic          lfsr_enable;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eof;
    logic          seed_err;
    logic          frame_err;
    logic [8:0]    word_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_lfsr = 0;

    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] cap_q[$];
    logic [DW-1:0] in_log[$];

    bit m_open = 0;
    bit m_byp = 0;
    bit m_ferr = 0;
    int m_cnt = 0;

    scrambler_xor_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bypass      (bypass),
        .err_clr     (err_clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_eof      (in_eof),
        .ks_in       (ks_in),
        .lfsr_enable (lfsr_enable),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .seed_err    (seed_err),
        .frame_err   (frame_err),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] adv18(input logic [PW-1:0] s);
        for (int i = 0; i < 18; i++) s = {s[PW-2:0], s[33] ^ s[26] ^ s[1] ^ s[0]};
        return s;
    endfunction

    always @(posedge clk) begin
        if (lfsr_load)        lfsr_q <= lfsr_seed;
        else if (lfsr_enable) lfsr_q <= adv18(lfsr_q);
    end
    assign ks_in = use_lfsr ? lfsr_q : ks_fixed;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Transaction-level reference: expected output stream, framing and lfsr pulses.
    always @(negedge clk) begin : monitor
        logic acc, eb, fset, in_frame;
        logic [DW+1:0] e;
        if (rst) begin
            exp_q.delete();
            m_open = 0; m_byp = 0; m_ferr = 0; m_cnt = 0;
        end else begin
            check_val("out_valid", out_valid, exp_q.size() != 0);
            check_val("word_cnt", word_cnt, m_cnt);
            check_val("frame_err", frame_err, m_ferr);
            if (out_valid && out_ready) begin
                cap_q.push_back(out_data);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("out_word", {out_sof, out_eof, out_data}, e);
                end
            end
            acc = in_valid && in_ready;
            eb = in_sof ? bypass : m_byp;
            check_val("lfsr_enable", lfsr_enable, acc && !eb);
            if (lfsr_enable) n_lfsr++;
            fset = 0;
            if (acc) begin
                in_log.push_back(in_data);
                exp_q.push_back({in_sof, in_eof, eb ? in_data : (in_data ^ ks_in[KL +: DW])});
                if (in_sof) begin
                    if (m_open) fset = 1;
                    m_cnt = 1; m_byp = bypass; in_frame = 1;
                end else begin
                    if (!m_open) fset = 1;
                    if (m_cnt < 511) m_cnt++;
                    in_frame = m_open;
                end
                m_open = 0;
                if (in_frame && !in_eof) begin
                    if (m_cnt == FL) fset = 1;
                    else m_open = 1;
                end
            end
            if (fset) m_ferr = 1;
            else if (err_clr) m_ferr = 0;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic s, input logic e);
        int n;
        n = 0;
        in_valid = 1; in_data = d; in_sof = s; in_eof = e;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_val("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; in_sof = 0; in_eof = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1;
        tick(1);
        err_clr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] seq[8];
        int c0, n0, b_in, b_cap;
        bit rdone;

        // Reset with zero keystream and a pending word.
        rst = 1; in_valid = 1; in_sof = 1; in_data = 18'h15555;
        tick(3);
        rst = 0;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_lfsr_en", lfsr_enable, 0);
        check_val("rst_seed_err", seed_err, 0);
        check_val("rst_frame_err", frame_err, 0);
        check_val("rst_word_cnt", word_cnt, 0);
        check_val("rst_out_data", out_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_val("seed_wait_ready", in_ready, 0);
            check_val("seed_wait_lfsr", lfsr_enable, 0);
        end
        in_valid = 0; in_sof = 0;

        ks_fixed = 34'h0_0001_0000;
        tick(1);
        check_val("seed_ready_1cyc", in_ready, 0);
        tick(1);
        check_val("seed_ready_2cyc", in_ready, 1);

        // Single known-answer word.
        out_ready = 1;
        n0 = n_lfsr;
        send_word(18'h3FFFF, 1, 0);
        check_val("ka_out_valid", out_valid, 1);
        check_val("ka_out_data", out_data, 18'h3FFFE);
        check_val("ka_out_sof", out_sof, 1);
        check_val("ka_lfsr_pulses", n_lfsr - n0, 1);
        send_word(18'h00123, 0, 1);
        tick(2);

        // Back-to-back words with the LFSR connected.
        lfsr_seed = 34'h1_2345_6789;
        lfsr_load = 1;
        tick(1);
        lfsr_load = 0;
        use_lfsr = 1;
        seq[0] = lfsr_seed;
        for (int k = 1; k < 8; k++) seq[k] = adv18(seq[k-1]);
        b_in = in_log.size(); b_cap = cap_q.size(); n0 = n_lfsr; c0 = cyc;
        for (int k = 0; k < 8; k++) send_word(18'($urandom), k == 0, k == 7);
        check_val("b2b_cycles", cyc - c0, 8);
        tick(3);
        check_val("b2b_pulses", n_lfsr - n0, 8);
        check_val("b2b_count", cap_q.size() - b_cap, 8);
        for (int k = 0; k < 8; k++)
            if (cap_q.size() > b_cap + k && in_log.size() > b_in + k)
                check_val("b2b_keystream", in_log[b_in+k] ^ cap_q[b_cap+k], seq[k][KL +: DW]);

        // Downstream stall for 4 cycles while streaming.
        fork
            for (int k = 0; k < 12; k++) send_word(18'($urandom), k == 0, k == 11);
            begin
                tick(3);
                out_ready = 0;
                for (int j = 1; j <= 4; j++) begin
                    tick(1);
                    if (j >= 2) begin
                        check_val("stall_in_ready", in_ready, 0);
                        check_val("stall_out_valid", out_valid, 1);
                    end
                end
                out_ready = 1;
            end
        join
        tick(4);

        // Bypassed frame; bypass dropped mid-frame must be ignored.
        b_in = in_log.size(); b_cap = cap_q.size(); n0 = n_lfsr;
        bypass = 1;
        send_word(18'($urandom), 1, 0);
        bypass = 0;
        for (int k = 1; k < 4; k++) send_word(18'($urandom), 0, k == 3);
        tick(3);
        check_val("byp_pulses", n_lfsr - n0, 0);
        for (int k = 0; k < 4; k++)
            if (cap_q.size() > b_cap + k && in_log.size() > b_in + k)
                check_val("byp_passthru", cap_q[b_cap+k], in_log[b_in+k]);
        n0 = n_lfsr;
        send_word(18'($urandom), 1, 0);
        send_word(18'($urandom), 0, 1);
        tick(3);
        check_val("post_byp_pulses", n_lfsr - n0, 2);

        // Keystream collapses to zero with two words buffered.
        use_lfsr = 0; ks_fixed = 34'h2_AAAA_5555;
        out_ready = 0;
        send_word(18'($urandom), 1, 0);
        send_word(18'($urandom), 0, 1);
        ks_fixed = '0;
        tick(1);
        check_val("flush_seed_err", seed_err, 1);
        check_val("flush_in_ready", in_ready, 0);
        tick(2);
        check_val("flush_hold_ready", in_ready, 0);
        check_val("flush_hold_valid", out_valid, 1);
        out_ready = 1;
        tick(3);
        check_val("flush_drained", out_valid, 0);
        check_val("flush_seedwait_ready", in_ready, 0);
        check_val("flush_err_sticky", seed_err, 1);
        pulse_clr();
        check_val("seed_err_clr", seed_err, 0);
        ks_fixed = 34'h0_00F0_0F00;
        tick(1);
        check_val("reseed_1cyc", in_ready, 0);
        tick(1);
        check_val("reseed_2cyc", in_ready, 1);
        use_lfsr = 1;

        // 257 words with no eof: length limit trips at word 256.
        pulse_clr();
        check_val("len_pre_err", frame_err, 0);
        for (int i = 1; i <= 257; i++) begin
            send_word(18'($urandom), i == 1, 0);
            if (i == 255) check_val("len_255_err", frame_err, 0);
            if (i == 256) begin
                check_val("len_256_err", frame_err, 1);
                check_val("len_256_cnt", word_cnt, 256);
            end
        end
        tick(2);

        // sof inside an open frame.
        pulse_clr();
        check_val("sof_pre_err", frame_err, 0);
        send_word(18'($urandom), 1, 0);
        send_word(18'($urandom), 1, 0);
        check_val("sof_in_frame_err", frame_err, 1);
        check_val("sof_in_frame_cnt", word_cnt, 1);
        send_word(18'($urandom), 0, 1);
        pulse_clr();

        // Random frames, bypass, protocol slips, backpressure and err_clr.
        rdone = 0;
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    int len;
                    bit drop_sof, drop_eof;
                    len = $urandom_range(1, 6);
                    drop_sof = ($urandom_range(0, 7) == 0);
                    drop_eof = ($urandom_range(0, 7) == 0);
                    bypass = 1'($urandom_range(0, 1));
                    for (int w = 0; w < len; w++) begin
                        if (w == 1) bypass = 1'($urandom_range(0, 1));
                        send_word(18'($urandom), (w == 0) && !drop_sof, (w == len - 1) && !drop_eof);
                    end
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                    err_clr = ($urandom_range(0, 9) == 0);
                end
                out_ready = 1;
                err_clr = 0;
            end
        join
        bypass = 0;
        tick(4);
        check_val("rand_drained", exp_q.size(), 0);

        // Reset in the middle of a frame with words in flight.
        out_ready = 0;
        send_word(18'($urandom), 1, 0);
        send_word(18'($urandom), 0, 0);
        rst = 1;
        tick(1);
        rst = 0;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_word_cnt", word_cnt, 0);
        check_val("midrst_in_ready", in_ready, 0);
        out_ready = 1;
        tick(2);
        check_val("midrst_ready_back", in_ready, 1);
        send_word(18'($urandom), 1, 0);
        send_word(18'($urandom), 0, 1);
        tick(3);
        check_val("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
